// File: rtl/npc_pc_unit.sv
// npc_pc_unit: fetch PC register and ID-stage next-PC selection (branch/jump/jr, one delay slot).
// Optional exception entry/return path is enabled by defining NPC_EXC_EN.
module npc_pc_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
`ifdef NPC_EXC_EN
  , parameter logic [31:0] EXC_VEC = 32'h0000_4180
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] pc_d,
  input  logic [2:0]  br_op,
  input  logic [1:0]  j_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
`ifdef NPC_EXC_EN
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
`endif
  output logic [31:0] pc_f,
  output logic [31:0] pc8_d,
  output logic        redirect,
  output logic        adel_f,
  output logic [31:0] redirect_cnt
);
  logic [31:0] fpc_q, fpc_d, cnt_q, cnt_d, br_tgt, j_tgt, jr_tgt, flow_nxt;
  logic        adel_q, adel_d, eq, neg, zero, cond, is_j, is_jr, mis;
  always_comb begin
    eq       = rs_val == rt_val;
    neg      = rs_val[31];
    zero     = rs_val == 32'd0;
    cond     = br_op == 3'd1 ? eq :
               br_op == 3'd2 ? !eq :
               br_op == 3'd3 ? !neg :
               br_op == 3'd4 ? !neg && !zero :
               br_op == 3'd5 ? neg || zero :
               br_op == 3'd6 ? neg : 1'b0;
    is_j     = j_op == 2'b01;
    is_jr    = j_op == 2'b10;
    mis      = is_jr && |rs_val[1:0];
    br_tgt   = pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    j_tgt    = {pc_d[31:28], instr_index, 2'b00};
    jr_tgt   = {rs_val[31:2], 2'b00};
    flow_nxt = is_j ? j_tgt : is_jr ? jr_tgt : cond ? br_tgt : fpc_q + 32'd4;
    redirect = is_j || is_jr || cond;
    pc8_d    = pc_d + 32'd8;
`ifdef NPC_EXC_EN
    // exception entry and return bypass the stall freeze
    fpc_d    = exc_req ? EXC_VEC : eret ? epc : stall ? fpc_q : mis ? EXC_VEC : flow_nxt;
    adel_d   = (exc_req || eret) ? 1'b0 : stall ? adel_q : mis;
    cnt_d    = (exc_req || eret || stall) ? cnt_q : cnt_q + {31'd0, redirect};
`else
    fpc_d    = stall ? fpc_q : flow_nxt;
    adel_d   = stall ? adel_q : mis;
    cnt_d    = stall ? cnt_q : cnt_q + {31'd0, redirect};
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q  <= PC_RESET;
      adel_q <= 1'b0;
      cnt_q  <= 32'd0;
    end else begin
      fpc_q  <= fpc_d;
      adel_q <= adel_d;
      cnt_q  <= cnt_d;
    end
  end
  assign pc_f         = fpc_q;
  assign adel_f       = adel_q;
  assign redirect_cnt = cnt_q;
endmodule
